ones_comp_accumulator: RTL and testbench

- Parametrised, multi-cycle ones' complement adder/accumulator.
- Sums a stream of WIDTH-bit words arriving over a valid/ready handshake, folding the end-around carry back in on every beat.
- Presents the final sum, its complement (checksum), a zero flag and a sticky signed-overflow flag.
- Generalises the team's 4-bit two-stage end-around-carry adder to any width and any packet length; used for header checksum generation and checking.

---
 rtl/ones_comp_accumulator.sv | 92 +++++++++
 tb/tb_ones_comp_accumulator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_comp_accumulator.sv
// Multi-cycle ones' complement accumulator with end-around carry, valid/ready input
// and a held result (sum, checksum, zero flag, sticky overflow, beat count).
module ones_comp_accumulator #(
  parameter int WIDTH     = 16,
  parameter int COUNT_W   = 8,
  parameter bit NORM_ZERO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic               last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Y,
  output logic [WIDTH-1:0]   CKSUM,
  output logic               is_zero,
  output logic               ovf,
  output logic [COUNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_acc;
  logic [COUNT_W-1:0] r_count;
  logic               r_ovf;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_fold;
  logic               w_clear;
  logic               w_beat;
  logic               w_ovf_beat;

  // One fold suffices: the folded low part never exceeds all-ones.
  assign w_sum      = {1'b0, r_acc} + {1'b0, A};
  assign w_fold     = w_sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
  assign w_clear    = start & (r_state != DONE);
  assign w_beat     = (r_state == ACCUM) & in_valid & ~start;
  assign w_ovf_beat = (r_acc[WIDTH-1] == A[WIDTH-1]) & (w_fold[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (!start && in_valid && last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_beat) begin
        r_acc <= w_fold;
        if (!(&r_count)) r_count <= r_count + COUNT_W'(1);
        if (w_ovf_beat) r_ovf <= 1'b1;
      end
    end
  end

  // CKSUM always follows the raw sum; only Y may fold -0 onto +0.
  assign Y       = (NORM_ZERO && (&r_acc)) ? '0 : r_acc;
  assign CKSUM   = ~r_acc;
  assign is_zero = (r_acc == '0) | (&r_acc);
  assign ovf     = r_ovf;
  assign count   = r_count;

endmodule

// File: tb/tb_ones_comp_accumulator.sv
// Scoreboard bench: three accumulator instances (4-bit/2-bit count, 16-bit, 16-bit with
// zero normalisation) share one stimulus stream; expected results are queued per packet.
module tb_ones_comp_accumulator;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, last, out_ready;
  logic [15:0] a;

  logic        rdy16, ov16, z16, ovf16;
  logic [15:0] y16, ck16;
  logic [7:0]  cnt16;
  logic        rdyn, ovn, zn, ovfn;
  logic [15:0] yn, ckn;
  logic [7:0]  cntn;
  logic        rdy4, ov4, z4, ovf4;
  logic [3:0]  y4, ck4;
  logic [1:0]  cnt4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] y16, yn, ck16;
    logic        z16, ovf16;
    logic [7:0]  cnt16;
    logic [3:0]  y4, ck4;
    logic        z4, ovf4;
    logic [1:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  logic [15:0] m_acc16;
  logic [3:0]  m_acc4;
  logic        m_ovf16, m_ovf4;
  int          m_beats;

  always #5 clk = ~clk;

  ones_comp_accumulator #(.WIDTH(16), .COUNT_W(8), .NORM_ZERO(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy16),
    .A(a), .last(last), .out_valid(ov16), .out_ready(out_ready), .Y(y16), .CKSUM(ck16),
    .is_zero(z16), .ovf(ovf16), .count(cnt16));

  ones_comp_accumulator #(.WIDTH(16), .COUNT_W(8), .NORM_ZERO(1'b1)) dut16n (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdyn),
    .A(a), .last(last), .out_valid(ovn), .out_ready(out_ready), .Y(yn), .CKSUM(ckn),
    .is_zero(zn), .ovf(ovfn), .count(cntn));

  ones_comp_accumulator #(.WIDTH(4), .COUNT_W(2), .NORM_ZERO(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy4),
    .A(a[3:0]), .last(last), .out_valid(ov4), .out_ready(out_ready), .Y(y4), .CKSUM(ck4),
    .is_zero(z4), .ovf(ovf4), .count(cnt4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc16 = '0; m_acc4 = '0; m_ovf16 = 1'b0; m_ovf4 = 1'b0; m_beats = 0;
  endtask

  task automatic model_beat(input logic [15:0] av);
    logic [16:0] s16;
    logic [15:0] n16;
    logic [4:0]  s4;
    logic [3:0]  n4;
    s16 = {1'b0, m_acc16} + {1'b0, av};
    n16 = s16[15:0] + {15'd0, s16[16]};
    if (m_acc16[15] == av[15] && n16[15] != av[15]) m_ovf16 = 1'b1;
    m_acc16 = n16;
    s4 = {1'b0, m_acc4} + {1'b0, av[3:0]};
    n4 = s4[3:0] + {3'd0, s4[4]};
    if (m_acc4[3] == av[3] && n4[3] != av[3]) m_ovf4 = 1'b1;
    m_acc4 = n4;
    m_beats++;
  endtask

  task automatic push_exp();
    exp_t e;
    e.y16   = m_acc16;
    e.yn    = (m_acc16 == 16'hFFFF) ? 16'h0000 : m_acc16;
    e.ck16  = ~m_acc16;
    e.z16   = (m_acc16 == 16'h0000) || (m_acc16 == 16'hFFFF);
    e.ovf16 = m_ovf16;
    e.cnt16 = (m_beats > 255) ? 8'd255 : 8'(m_beats);
    e.y4    = m_acc4;
    e.ck4   = ~m_acc4;
    e.z4    = (m_acc4 == 4'h0) || (m_acc4 == 4'hF);
    e.ovf4  = m_ovf4;
    e.cnt4  = (m_beats > 3) ? 2'd3 : 2'(m_beats);
    sb.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ovalid"}, {ov4, ovn, ov16}, 3'b000);
    chk({tag, "_irdy"}, {rdy4, rdyn, rdy16}, 3'b000);
    chk({tag, "_y16"}, y16, 16'h0000);
    chk({tag, "_ck16"}, ck16, 16'hFFFF);
    chk({tag, "_y4ck4"}, {y4, ck4}, 8'h0F);
    chk({tag, "_flags"}, {z16, zn, z4, ovf16, ovfn, ovf4}, 6'b111000);
    chk({tag, "_cnt"}, {cnt16, cntn, 6'(cnt4)}, 22'd0);
  endtask

  task automatic pkt_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    chk("start_rdy", {rdy4, rdyn, rdy16}, 3'b111);
  endtask

  task automatic beat(input logic [15:0] av, input logic lst);
    chk("beat_rdy", {rdy4, rdyn, rdy16}, 3'b111);
    in_valid = 1'b1; a = av; last = lst;
    if (lst) chk("pre_last_ovalid", {ov4, ovn, ov16}, 3'b000);
    tick();
    in_valid = 1'b0; last = 1'b0;
    model_beat(av);
    if (lst) begin
      push_exp();
      chk("latency_ovalid", {ov4, ovn, ov16}, 3'b111);
    end
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int w;
    w = 0;
    while (ov16 !== 1'b1 && w < TO) begin
      tick();
      w++;
    end
    if (w >= TO) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_y16"}, y16, e.y16);
    chk({tag, "_ck16"}, ck16, e.ck16);
    chk({tag, "_yn"}, yn, e.yn);
    chk({tag, "_ckn"}, ckn, e.ck16);
    chk({tag, "_z16"}, {z16, zn}, {e.z16, e.z16});
    chk({tag, "_ovf16"}, {ovf16, ovfn}, {e.ovf16, e.ovf16});
    chk({tag, "_cnt16"}, {cnt16, cntn}, {e.cnt16, e.cnt16});
    chk({tag, "_y4"}, y4, e.y4);
    chk({tag, "_ck4"}, ck4, e.ck4);
    chk({tag, "_z4ovf4"}, {z4, ovf4}, {e.z4, e.ovf4});
    chk({tag, "_cnt4"}, cnt4, e.cnt4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {ov4, ovn, ov16, rdy4, rdyn, rdy16}, 6'd0);
  endtask

  logic [15:0] ip_hdr [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ip_hdr = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
               16'h0000, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0; out_ready = 1'b0; a = '0;
    model_clear();
    #12;
    chk_reset("reset");
    #5 rst_n = 1'b1;
    tick();

    // IDLE ignores in_valid without start
    in_valid = 1'b1; a = 16'h0001; last = 1'b1;
    tick(); tick();
    in_valid = 1'b0; last = 1'b0;
    chk("idle_ignore", {rdy16, ov16, cnt16}, 10'd0);

    pkt_start();
    beat(16'h0005, 1'b0);
    beat(16'h0003, 1'b1);
    chk("t1_y4", y4, 4'b1000);
    chk("t1_ck4", ck4, 4'b0111);
    chk("t1_ovf4_cnt4", {ovf4, cnt4}, 3'b110);
    collect("t1");

    pkt_start();
    beat(16'h000C, 1'b0);
    beat(16'h0006, 1'b1);
    chk("t2_y4", y4, 4'b0011);
    chk("t2_ovf4_z4", {ovf4, z4}, 2'b00);
    collect("t2");

    pkt_start();
    for (int i = 0; i < 10; i++) beat(ip_hdr[i], i == 9);
    chk("ip_y16", y16, 16'h479E);
    chk("ip_ck16", ck16, 16'hB861);
    collect("ip");

    pkt_start();
    for (int i = 0; i < 10; i++) beat((i == 5) ? 16'hB861 : ip_hdr[i], i == 9);
    chk("ipchk_y16", y16, 16'hFFFF);
    chk("ipchk_ck16", ck16, 16'h0000);
    chk("ipchk_z16", z16, 1'b1);
    chk("ipchk_yn", yn, 16'h0000);
    collect("ipchk");

    pkt_start();
    beat(16'h1234, 1'b0);
    beat(16'h0F0F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; in_valid = ~i[0]; a = 16'hFFFF; last = 1'b1;
      tick();
      chk("bp_irdy", {rdy4, rdyn, rdy16}, 3'b000);
      chk("bp_ovalid", {ov4, ovn, ov16}, 3'b111);
      chk("bp_y16", y16, 16'h2143);
      chk("bp_cnt16", cnt16, 8'd2);
    end
    start = 1'b0; in_valid = 1'b0; last = 1'b0;
    collect("bp");

    pkt_start();
    beat(16'h0101, 1'b0);
    beat(16'h0202, 1'b0);
    beat(16'h0404, 1'b0);
    chk("rs_cnt3", cnt16, 8'd3);
    start = 1'b1; in_valid = 1'b1; a = 16'h7777; last = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; last = 1'b0;
    model_clear();
    chk("rs_cleared", {cnt16, y16, 6'(cnt4), y4}, 34'd0);
    chk("rs_rdy", {rdy4, rdyn, rdy16}, 3'b111);
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b1);
    chk("rs_y16", y16, 16'h3333);
    collect("rs");

    pkt_start();
    beat(16'h5555, 1'b0);
    beat(16'h6666, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    model_clear();
    #2 rst_n = 1'b1;
    tick();

    pkt_start();
    beat(16'h8000, 1'b0);
    beat(16'h8000, 1'b1);
    chk("neg_y16", y16, 16'h0001);
    chk("neg_ovf16", ovf16, 1'b1);
    chk("neg_z4", z4, 1'b1);
    collect("neg");

    pkt_start();
    for (int i = 1; i <= 6; i++) beat(16'(i * 16'h0101), i == 6);
    chk("sat_cnt4", cnt4, 2'd3);
    chk("sat_cnt16", cnt16, 8'd6);
    collect("sat");

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
